// File: rtl/output_writeback_pkg.sv
// Purpose: shared types and sizes for the output writeback path (row width, FIFO depth, FSM states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package output_writeback_pkg;

    localparam int N_DIM_ARRAY    = 16;   // activations per output row
    localparam int ACT_DATA_WIDTH = 8;    // bits per activation
    localparam int WB_FIFO_DEPTH  = 4;    // default row FIFO depth (power of 2, >= 2)

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_RUN,
        WB_DRAIN,
        WB_DONE
    } wb_state_t;

endpackage

// File: rtl/output_writeback_fifo.sv
// Purpose: synchronous FIFO of {addr,row} entries with flush; push and pop may coincide even when full.
// Latency: a push at edge t is visible at the head (rdata) from cycle t+1.
// Backpressure: the caller gates push on count; push while full without a pop is ignored.
// Ports: clk/reset, push/pop/flush strobes, wdata in, rdata = head entry, count and empty status.
module wb_row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign push_ok = push && ((count < CW'(DEPTH)) || pop_ok);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/output_writeback.sv
// Purpose: packs PE-array output rows into memory words and writes them at base+k*stride via req/gnt.
// Latency: a row accepted at edge t can be requested from cycle t+1; done pulses the cycle after the last gnt.
// Backpressure: registered stall_array rises when the FIFO will hold >= DEPTH-1 rows; unaccepted rows set overflow_err.
// Ports: start/abort/config in; in_valid/in_data rows in; mem_req/mem_addr/mem_wdata/mem_gnt write port;
//        stall_array, busy, done, overflow_err status out.
module output_writeback
    import output_writeback_pkg::*;
#(
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic                                          abort,
    input  logic [ADDR_WIDTH-1:0]                         base_addr,
    input  logic [ADDR_WIDTH-1:0]                         addr_stride,
    input  logic [CNT_WIDTH-1:0]                          num_rows,
    input  logic                                          in_valid,
    input  logic [N_DIM_ARRAY-1:0][ACT_DATA_WIDTH-1:0]    in_data,
    output logic                                          stall_array,
    output logic                                          mem_req,
    output logic [ADDR_WIDTH-1:0]                         mem_addr,
    output logic [N_DIM_ARRAY*ACT_DATA_WIDTH-1:0]         mem_wdata,
    input  logic                                          mem_gnt,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          overflow_err
);

    localparam int ROW_W = N_DIM_ARRAY * ACT_DATA_WIDTH;
    localparam int ENT_W = ADDR_WIDTH + ROW_W;
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

    wb_state_t             state;
    wb_state_t             state_nxt;
    logic [ADDR_WIDTH-1:0] cfg_stride;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [CNT_WIDTH-1:0]  cfg_rows;
    logic [CNT_WIDTH-1:0]  acc_cnt;
    logic [CNT_WIDTH-1:0]  wr_cnt;
    logic [ROW_W-1:0]      row_packed;
    logic [ENT_W-1:0]      fifo_rdata;
    logic [FCW-1:0]        fifo_count;
    logic [FCW-1:0]        count_nxt;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  start_go;

    // Activation k lands in bits [k*ACT +: ACT]; no reordering or saturation.
    always_comb begin
        row_packed = '0;
        for (int k = 0; k < N_DIM_ARRAY; k++) begin
            row_packed[k*ACT_DATA_WIDTH +: ACT_DATA_WIDTH] = in_data[k];
        end
    end

    assign start_go  = start && !abort && (state == WB_IDLE);
    assign mem_req   = ((state == WB_RUN) || (state == WB_DRAIN)) && !fifo_empty;
    assign pop       = mem_req && mem_gnt;
    assign push      = (state == WB_RUN) && in_valid && !abort &&
                       ((fifo_count < FCW'(FIFO_DEPTH)) || pop);
    assign drop      = in_valid && !push;
    assign count_nxt = abort ? '0 : (fifo_count + FCW'(push) - FCW'(pop));

    // Head entry is held in the FIFO, so address and data stay stable until granted.
    assign mem_addr  = mem_req ? fifo_rdata[ENT_W-1 -: ADDR_WIDTH] : '0;
    assign mem_wdata = mem_req ? fifo_rdata[ROW_W-1:0] : '0;

    wb_row_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (abort),
        .wdata ({next_addr, row_packed}),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WB_IDLE;
        else       state <= state_nxt;
    end

    // Transitions look at the post-increment count so no extra row slips in after the last one.
    always_comb begin
        state_nxt = state;
        busy      = (state != WB_IDLE);
        done      = (state == WB_DONE);
        case (state)
            WB_IDLE:  if (start_go) state_nxt = (num_rows == '0) ? WB_DONE : WB_RUN;
            WB_RUN:   if (push && (acc_cnt + CNT_WIDTH'(1) == cfg_rows)) state_nxt = WB_DRAIN;
            WB_DRAIN: if (pop && (wr_cnt + CNT_WIDTH'(1) == cfg_rows)) state_nxt = WB_DONE;
            WB_DONE:  state_nxt = WB_IDLE;
            default:  state_nxt = WB_IDLE;
        endcase
        if (abort) state_nxt = WB_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_stride   <= '0;
            cfg_rows     <= '0;
            next_addr    <= '0;
            acc_cnt      <= '0;
            wr_cnt       <= '0;
            overflow_err <= 1'b0;
            stall_array  <= 1'b0;
        end else if (abort) begin
            acc_cnt      <= '0;
            wr_cnt       <= '0;
            overflow_err <= 1'b0;
            stall_array  <= 1'b0;
        end else begin
            if (start_go) begin
                cfg_stride   <= addr_stride;
                cfg_rows     <= num_rows;
                next_addr    <= base_addr;
                acc_cnt      <= '0;
                wr_cnt       <= '0;
                overflow_err <= 1'b0;
            end else begin
                if (push) begin
                    acc_cnt   <= acc_cnt + CNT_WIDTH'(1);
                    next_addr <= next_addr + cfg_stride;   // wraps modulo 2^ADDR_WIDTH
                end
                if (pop)  wr_cnt       <= wr_cnt + CNT_WIDTH'(1);
                if (drop) overflow_err <= 1'b1;
            end
            // One row of margin: the array sees stall one cycle before the FIFO is actually full.
            stall_array <= (count_nxt >= FCW'(FIFO_DEPTH - 1));
        end
    end

endmodule

// File: tb/tb_output_writeback.sv
module tb_output_writeback;
    import output_writeback_pkg::*;

    localparam int AW = 16;
    localparam int CW = 16;
    localparam int DW = N_DIM_ARRAY * ACT_DATA_WIDTH;

    typedef logic [N_DIM_ARRAY-1:0][ACT_DATA_WIDTH-1:0] row_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] addr_stride;
    logic [CW-1:0] num_rows;
    logic          in_valid;
    row_t          in_data;
    logic          stall_array;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_gnt;
    logic          busy;
    logic          done;
    logic          overflow_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    wr_t           sb[$];
    wr_t           mon_e;
    int            wr_cyc[$];
    logic [AW-1:0] wr_addr[$];
    int            done_cyc[$];

    output_writeback dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .base_addr    (base_addr),
        .addr_stride  (addr_stride),
        .num_rows     (num_rows),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .stall_array  (stall_array),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .busy         (busy),
        .done         (done),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] byte_of(input int seed, input int k);
        return 8'((seed * 37 + k * 5 + 1) & 255);
    endfunction

    function automatic row_t row_in(input int seed);
        row_t r;
        for (int k = 0; k < N_DIM_ARRAY; k++) r[k] = byte_of(seed, k);
        return r;
    endfunction

    function automatic logic [DW-1:0] exp_word(input int seed);
        logic [DW-1:0] w;
        for (int k = 0; k < N_DIM_ARRAY; k++) w[k*8 +: 8] = byte_of(seed, k);
        return w;
    endfunction

    // Scoreboard: every granted write is compared against the oldest expected write.
    always @(negedge clk) begin
        if (!reset && mem_req && mem_gnt) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(mem_addr);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_write addr=%h (no write expected)", mem_addr);
            end else begin
                mon_e = sb.pop_front();
                if (mem_addr !== mon_e.addr || mem_wdata !== mon_e.data) begin
                    errors++;
                    $display("FAIL sb_write got addr=%h data=%h expected addr=%h data=%h",
                             mem_addr, mem_wdata, mon_e.addr, mon_e.data);
                end
            end
        end
        if (!reset && done) done_cyc.push_back(cyc);
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called and returns at posedge+1.
    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [CW-1:0] n);
        base_addr = b; addr_stride = s; num_rows = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Sends n rows honouring stall_array, recording each expected write. Returns at posedge+1.
    task automatic feed_rows(input int n, input int seed0, input logic [AW-1:0] a0, input logic [AW-1:0] s);
        int  sent  = 0;
        int  guard = 0;
        wr_t e;
        while (sent < n && guard < 200) begin
            if (!stall_array) begin
                in_valid = 1'b1;
                in_data  = row_in(seed0 + sent);
                e.addr   = AW'(a0 + s * AW'(sent));
                e.data   = exp_word(seed0 + sent);
                sb.push_back(e);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0;
        if (sent < n) begin
            checks++; errors++;
            $display("FAIL feed_timeout sent=%0d required=%0d", sent, n);
        end
    endtask

    task automatic wait_done(input int budget, output bit got);
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; abort = 0; in_valid = 0; mem_gnt = 0;
        base_addr = '0; addr_stride = '0; num_rows = '0; in_data = '0;
        repeat (3) @(negedge clk);
        checks++; if ({mem_req, busy, done, stall_array, overflow_err} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b required=00000",
                               {mem_req, busy, done, stall_array, overflow_err});
        end
        checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++; $display("FAIL reset_bus got addr=%h data=%h required 0", mem_addr, mem_wdata);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int b  = wr_cyc.size();
        int bd = done_cyc.size();
        bit got;
        mem_gnt = 1'b1;
        do_start(16'h0010, 16'h0004, 16'd3);
        feed_rows(3, 1, 16'h0010, 16'h0004);
        wait_done(20, got);
        checks++; if (!got) begin errors++; $display("FAIL b2b_done got=0 required=1"); end
        checks++; if (wr_cyc.size() - b !== 3) begin
            errors++; $display("FAIL b2b_write_count got=%0d required=3", wr_cyc.size() - b);
        end else begin
            checks++; if (wr_cyc[b+1] !== wr_cyc[b] + 1 || wr_cyc[b+2] !== wr_cyc[b] + 2) begin
                errors++; $display("FAIL b2b_consecutive cycles=%0d,%0d,%0d required consecutive",
                                   wr_cyc[b], wr_cyc[b+1], wr_cyc[b+2]);
            end
            checks++; if (done_cyc.size() - bd !== 1 || done_cyc[bd] !== wr_cyc[b+2] + 1) begin
                errors++; $display("FAIL b2b_done_timing done_pulses=%0d last_wr_cyc=%0d required one pulse next cycle",
                                   done_cyc.size() - bd, wr_cyc[b+2]);
            end
        end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL b2b_sb_left got=%0d required=0", sb.size()); end
    endtask

    task automatic test_backpressure();
        int  mc = 0;
        bit  dropped = 0;
        bit  got;
        wr_t e;
        mem_gnt = 1'b0;
        do_start(16'h0100, 16'h0001, 16'd8);
        in_valid = 1'b1; in_data = row_in(100);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            if (mc < 4) begin
                e.addr = 16'h0100 + AW'(mc); e.data = exp_word(100 + i);
                sb.push_back(e); mc++;
            end else begin
                dropped = 1'b1;
            end
            #1;
            if (i < 9) in_data = row_in(101 + i);
            else       in_valid = 1'b0;
            @(negedge clk);
            checks++; if (stall_array !== (mc >= 3)) begin
                errors++; $display("FAIL bp_stall i=%0d got=%b required=%b", i, stall_array, mc >= 3);
            end
            checks++; if (overflow_err !== dropped) begin
                errors++; $display("FAIL bp_overflow i=%0d got=%b required=%b", i, overflow_err, dropped);
            end
            checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0100 || mem_wdata !== exp_word(100)) begin
                errors++; $display("FAIL bp_head_stable i=%0d got req=%b addr=%h required req=1 addr=0100",
                                   i, mem_req, mem_addr);
            end
        end
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        feed_rows(4, 110, 16'h0104, 16'h0001);
        wait_done(30, got);
        checks++; if (!got) begin errors++; $display("FAIL bp_done got=0 required=1"); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL bp_sb_left got=%0d required=0", sb.size()); end
    endtask

    task automatic test_addr_wrap();
        int b = wr_addr.size();
        bit got;
        mem_gnt = 1'b1;
        do_start(16'hFFFC, 16'h0004, 16'd2);
        checks++; if (overflow_err !== 1'b0) begin
            errors++; $display("FAIL wrap_start_clears_overflow got=%b required=0", overflow_err);
        end
        feed_rows(2, 20, 16'hFFFC, 16'h0004);
        wait_done(20, got);
        checks++; if (!got) begin errors++; $display("FAIL wrap_done got=0 required=1"); end
        checks++; if (wr_addr.size() - b !== 2) begin
            errors++; $display("FAIL wrap_count got=%0d required=2", wr_addr.size() - b);
        end else if (wr_addr[b] !== 16'hFFFC || wr_addr[b+1] !== 16'h0000) begin
            errors++; $display("FAIL wrap_addrs got=%h,%h required=fffc,0000", wr_addr[b], wr_addr[b+1]);
        end
    endtask

    task automatic test_zero_rows();
        int b = wr_cyc.size();
        mem_gnt = 1'b1;
        do_start(16'h0000, 16'h0001, 16'd0);
        @(negedge clk);
        checks++; if ({busy, done, mem_req} !== 3'b110) begin
            errors++; $display("FAIL zero_first_cycle got busy,done,req=%b required=110", {busy, done, mem_req});
        end
        @(negedge clk);
        checks++; if ({busy, done, mem_req} !== 3'b000) begin
            errors++; $display("FAIL zero_second_cycle got busy,done,req=%b required=000", {busy, done, mem_req});
        end
        checks++; if (wr_cyc.size() !== b) begin
            errors++; $display("FAIL zero_no_write got=%0d required=0", wr_cyc.size() - b);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int b  = wr_cyc.size();
        int bd = done_cyc.size();
        bit got;
        mem_gnt = 1'b0;
        do_start(16'h0200, 16'h0002, 16'd3);
        feed_rows(3, 30, 16'h0200, 16'h0002);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        checks++; if ({mem_req, busy, done, stall_array} !== 4'b0000) begin
            errors++; $display("FAIL abort_outputs got req,busy,done,stall=%b required=0000",
                               {mem_req, busy, done, stall_array});
        end
        checks++; if (wr_cyc.size() - b !== 1 || sb.size() !== 2) begin
            errors++; $display("FAIL abort_writes got=%0d pending=%0d required 1 and 2", wr_cyc.size() - b, sb.size());
        end
        sb.delete();
        repeat (4) @(negedge clk);
        checks++; if (done_cyc.size() !== bd) begin
            errors++; $display("FAIL abort_no_done got=%0d pulses required=0", done_cyc.size() - bd);
        end
        // abort and start together in IDLE: abort wins, job must not begin
        @(posedge clk); #1;
        base_addr = 16'h0040; addr_stride = 16'h0001; num_rows = 16'd1; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_beats_start busy=%b required=0", busy); end
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        do_start(16'h0040, 16'h0001, 16'd1);
        feed_rows(1, 40, 16'h0040, 16'h0001);
        wait_done(20, got);
        checks++; if (!got) begin errors++; $display("FAIL abort_restart_done got=0 required=1"); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL abort_restart_sb got=%0d required=0", sb.size()); end
    endtask

    task automatic test_reset_mid_drain();
        int b;
        bit got;
        mem_gnt = 1'b0;
        do_start(16'h0300, 16'h0001, 16'd2);
        feed_rows(2, 50, 16'h0300, 16'h0001);
        @(negedge clk);
        checks++; if ({busy, mem_req} !== 2'b11) begin
            errors++; $display("FAIL rst_pre_state got busy,req=%b required=11", {busy, mem_req});
        end
        #2 reset = 1'b1;
        #1;
        checks++; if ({mem_req, busy, done, stall_array, overflow_err} !== 5'b0 ||
                      mem_addr !== '0 || mem_wdata !== '0) begin
            errors++; $display("FAIL rst_async got flags=%b addr=%h required all 0",
                               {mem_req, busy, done, stall_array, overflow_err}, mem_addr);
        end
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if ({mem_req, busy} !== 2'b00) begin
            errors++; $display("FAIL rst_after_release got req,busy=%b required=00", {mem_req, busy});
        end
        b = wr_cyc.size();
        mem_gnt = 1'b1;
        do_start(16'h0500, 16'h0001, 16'd1);
        feed_rows(1, 60, 16'h0500, 16'h0001);
        wait_done(20, got);
        checks++; if (!got || wr_cyc.size() - b !== 1) begin
            errors++; $display("FAIL rst_fifo_empty done=%b writes=%0d required done=1 writes=1", got, wr_cyc.size() - b);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_addr_wrap();
        test_zero_rows();
        test_abort();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
